// File: rtl/lab04_add_seq_if.sv
`default_nettype none
// ============================================================================
// lab04_add_seq_if : request/result and adder-slice signals of lab04_add_seq
// Revision: 1.0
// ============================================================================
interface lab04_add_seq_if #(
  parameter int CHUNKS = 4
);
  localparam int N = 3 * CHUNKS;

  logic         start;
  logic         op;
  logic [N-1:0] A_in;
  logic [N-1:0] B_in;
  logic         CI_in;

  logic [2:0]   ADD_A;
  logic [2:0]   ADD_B;
  logic         ADD_CI;
  logic [2:0]   ADD_S;
  logic         ADD_CO;

  logic         busy;
  logic         done;
  logic [N-1:0] S_out;
  logic         CO_out;

  modport slave (
    input  start, op, A_in, B_in, CI_in, ADD_S, ADD_CO,
    output ADD_A, ADD_B, ADD_CI, busy, done, S_out, CO_out
  );

  modport master (
    output start, op, A_in, B_in, CI_in, ADD_S, ADD_CO,
    input  ADD_A, ADD_B, ADD_CI, busy, done, S_out, CO_out
  );
endinterface
`default_nettype wire

// File: rtl/lab04_add_seq.sv
`default_nettype none
// ============================================================================
// lab04_add_seq : wide add/subtract through one shared 3-bit adder slice,
//                 one chunk per clock, LSB chunk first.
// Revision: 1.0
// ============================================================================
module lab04_add_seq #(
  parameter int CHUNKS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  lab04_add_seq_if.slave  bus
);
  localparam int             IW     = $clog2(CHUNKS);
  localparam logic [IW-1:0]  C_LAST = IW'(CHUNKS - 1);

  typedef logic [CHUNKS-1:0][2:0] chunks_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  chunks_t        opa_q, opa_d;
  chunks_t        opb_q, opb_d;
  chunks_t        result_q, result_d;
  logic           carry_q, carry_d;
  logic           co_q, co_d;
  logic [IW-1:0]  idx_q, idx_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      co_q     <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      co_q     <= co_d;
      idx_q    <= idx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    carry_d  = carry_q;
    co_d     = co_q;
    idx_d    = idx_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.start) begin
          // Subtract is A + ~B + 1, so the inversion and the +1 are folded in here.
          opa_d    = bus.A_in;
          opb_d    = bus.op ? ~bus.B_in : bus.B_in;
          carry_d  = bus.op ? 1'b1 : bus.CI_in;
          idx_d    = '0;
          result_d = '0;
          co_d     = 1'b0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        result_d[idx_q] = bus.ADD_S;
        carry_d         = bus.ADD_CO;
        idx_d           = idx_q + IW'(1);
        if (idx_q == C_LAST) begin
          co_d    = bus.ADD_CO;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Slice drive comes from registers only, so start has no path to the adder.
  assign bus.busy   = (state_q == S_RUN);
  assign bus.done   = (state_q == S_DONE);
  assign bus.ADD_A  = (state_q == S_RUN) ? opa_q[idx_q] : 3'b000;
  assign bus.ADD_B  = (state_q == S_RUN) ? opb_q[idx_q] : 3'b000;
  assign bus.ADD_CI = (state_q == S_RUN) ? carry_q : 1'b0;
  assign bus.S_out  = result_q;
  assign bus.CO_out = co_q;
endmodule
`default_nettype wire

// File: tb/tb_lab04_add_seq.sv
`default_nettype none
// ============================================================================
// tb_lab04_add_seq : directed and random add/subtract runs against an
//                    arithmetic reference, with an ideal 3-bit adder slice.
// Revision: 1.0
// ============================================================================
module tb_lab04_add_seq;
  localparam int CHUNKS = 4;
  localparam int N      = 3 * CHUNKS;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  lab04_add_seq_if #(.CHUNKS(CHUNKS)) bus ();

  lab04_add_seq #(.CHUNKS(CHUNKS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign {bus.ADD_CO, bus.ADD_S} = {1'b0, bus.ADD_A} + {1'b0, bus.ADD_B} + {3'b000, bus.ADD_CI};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {carry/no-borrow, result} straight from unsigned arithmetic
  function automatic logic [N:0] ref_model(input logic o, input logic [N-1:0] a,
                                            input logic [N-1:0] b, input logic ci);
    logic [N:0] r;
    if (o) begin
      r[N-1:0] = a - b;
      r[N]     = (a >= b);
    end else begin
      r = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};
    end
    return r;
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_adda"}, 32'(bus.ADD_A), 32'd0);
    chk({tag, "_addb"}, 32'(bus.ADD_B), 32'd0);
    chk({tag, "_addci"}, 32'(bus.ADD_CI), 32'd0);
  endtask

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic run_op(input logic o, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic ci, input bit mid_start, input string tag);
    logic [N:0]   exp;
    logic [N-1:0] bx;
    exp = ref_model(o, a, b, ci);
    bx  = o ? ~b : b;
    bus.start = 1'b1;
    bus.op    = o;
    bus.A_in  = a;
    bus.B_in  = b;
    bus.CI_in = ci;
    for (int i = 0; i < CHUNKS; i++) begin
      @(negedge clk);
      bus.start = (mid_start && i == 1);
      bus.op    = 1'($urandom);
      bus.A_in  = N'($urandom);
      bus.B_in  = N'($urandom);
      bus.CI_in = 1'($urandom);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      chk({tag, "_done_early"}, 32'(bus.done), 32'd0);
      chk({tag, "_adda"}, 32'(bus.ADD_A), 32'(a[3*i +: 3]));
      chk({tag, "_addb"}, 32'(bus.ADD_B), 32'(bx[3*i +: 3]));
      if (i == 0) begin
        chk({tag, "_ci0"}, 32'(bus.ADD_CI), 32'(o ? 1'b1 : ci));
        chk({tag, "_sclr"}, 32'(bus.S_out), 32'd0);
        chk({tag, "_coclr"}, 32'(bus.CO_out), 32'd0);
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    chk({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
    chk({tag, "_s"}, 32'(bus.S_out), 32'(exp[N-1:0]));
    chk({tag, "_co"}, 32'(bus.CO_out), 32'(exp[N]));
  endtask

  initial begin
    logic [N:0]   exp;
    logic [N-1:0] ra, rb;
    logic         ro, rc;
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.op    = 1'($urandom);
    bus.A_in  = N'($urandom);
    bus.B_in  = N'($urandom);
    bus.CI_in = 1'($urandom);

    repeat (3) @(negedge clk);
    check_idle_outputs("rst");
    chk("rst_s", 32'(bus.S_out), 32'd0);
    chk("rst_co", 32'(bus.CO_out), 32'd0);
    bus.start = 1'b0;
    rst_n     = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("idle");

    run_op(1'b0, 12'h0FF, 12'h001, 1'b0, 1'b0, "add_0ff");
    @(negedge clk);
    chk("add_done_single", 32'(bus.done), 32'd0);
    chk("add_hold", 32'(bus.S_out), 32'h100);
    run_op(1'b0, 12'hFFF, 12'h001, 1'b0, 1'b0, "wrap");
    @(negedge clk);
    run_op(1'b0, 12'h000, 12'h000, 1'b1, 1'b0, "ci_only");
    @(negedge clk);
    run_op(1'b1, 12'h007, 12'h005, 1'($urandom), 1'b0, "sub_pos");
    @(negedge clk);
    run_op(1'b1, 12'h005, 12'h007, 1'($urandom), 1'b0, "sub_neg");
    @(negedge clk);

    // Start mid-RUN is ignored, then a back-to-back start in the done cycle
    run_op(1'b0, 12'h123, 12'h456, 1'b0, 1'b1, "midstart");
    run_op(1'b0, 12'h001, 12'h002, 1'b0, 1'b0, "b2b");
    chk("b2b_s_lit", 32'(bus.S_out), 32'h003);
    @(negedge clk);
    chk("b2b_single_done", 32'(bus.done), 32'd0);

    // Asynchronous reset during the second RUN cycle
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.A_in  = 12'hABC;
    bus.B_in  = 12'h321;
    bus.CI_in = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("arst");
    chk("arst_s", 32'(bus.S_out), 32'd0);
    chk("arst_co", 32'(bus.CO_out), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < CHUNKS + 2; i++) begin
      @(negedge clk);
      chk("arst_nodone", 32'(bus.done), 32'd0);
    end
    run_op(1'b0, 12'h555, 12'h2AB, 1'b0, 1'b0, "post_rst");
    @(negedge clk);

    // Random operations with random gaps, including back-to-back starts
    for (int k = 0; k < 25; k++) begin
      int gap;
      ro = 1'($urandom);
      ra = N'($urandom);
      rb = N'($urandom);
      rc = 1'($urandom);
      run_op(ro, ra, rb, rc, ($urandom_range(0, 3) == 0), "rnd");
      exp = ref_model(ro, ra, rb, rc);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        chk("rnd_idle_done", 32'(bus.done), 32'd0);
        chk("rnd_idle_hold", 32'(bus.S_out), 32'(exp[N-1:0]));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
